div_ui_ctrl: RTL
================

Name: div_ui_ctrl

Overview:
- Sequencing controller for the 4-bit calculator-style divider.
- Detects button presses and holds the numerator and denominator operand registers.
- Drives a start/done handshake to an iterative divider datapath, latches its result and remainder, and selects what the LEDs show.
- Replaces the free-running 2-bit step counter with an explicit FSM, including divide-by-zero detection.

Parameters:
WIDTH, 4, operand/result/LED width
TIMEOUT, 32, max cycles in WAIT before error (used only with DIV_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
up  input  1  increment button level, active-high, already synchronized
down  input  1  decrement button level, active-high, already synchronized
ok  input  1  advance button level, active-high, already synchronized
div_done  input  1  divider completion pulse
div_result  input  WIDTH  divider quotient, valid with div_done
div_rest  input  WIDTH  divider remainder, valid with div_done
div_start  output  1  one-cycle start pulse to divider
num  output  WIDTH  numerator register, to divider
den  output  WIDTH  denominator register, to divider
state  output  3  current FSM state code
err  output  1  high while in ERR
leds  output  WIDTH  display value

Behaviour:
- Reset (async, rst=1):
  - state=NUM(0); num, den, res_q, rest_q = 0.
  - Previous-sample registers for up, down and ok = 0.
  - div_start=0, err=0, leds=0.
  - Reset mid-operation abandons the division. Any div_done arriving afterwards is ignored.
- Press detection:
  - A press is detected at the clock edge where the input samples 1 and its previous sample was 0.
  - Holding a button gives exactly one press.
  - The FSM acts on that same edge.
- State codes: NUM=0, DEN=1, START=2, WAIT=3, RES=4, REST=5, ERR=6. Codes 7 and unused go to NUM on the next edge.
- NUM:
  - up press: num+1. down press: num-1. Modulo 2^WIDTH, so 15→0 and 0→15.
  - up and down pressed together: no change.
  - ok press: go to DEN.
- DEN:
  - up/down edit den, same rules as NUM.
  - ok press with den==0: go to ERR.
  - ok press with den!=0: go to START.
  - If ok and up/down are pressed on the same edge, the edit applies first and the den==0 check uses the edited value.
- START:
  - div_start=1 for exactly this one cycle; unconditionally go to WAIT.
- WAIT:
  - div_start=0. On div_done=1: res_q←div_result, rest_q←div_rest, go to RES.
  - All button presses are ignored in START and WAIT, including presses whose edge falls there.
- RES: ok press goes to REST.
- REST: ok press goes to NUM. num and den keep their values.
- ERR:
  - err=1. ok press goes to DEN so the denominator can be re-entered.
  - up/down are ignored.
- div_done outside WAIT is ignored.
- leds is combinational from registered state:
  - NUM→num, DEN→den, START/WAIT→0, RES→res_q, REST→rest_q.
  - ERR→all ones (4'b1111 at WIDTH=4).
- Timing:
  - From the ok edge in DEN to the div_start pulse: 1 cycle.
  - res_q is visible on leds the cycle after the div_done edge.
- num and den are stable from START until exit from WAIT; the divider may sample them at any time in that window.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without div_done, go to ERR with leds=4'b1010 (alternating-bit pattern) instead of all ones. err=1.
  - If div_done arrives in the same cycle the limit is reached, div_done wins.
- When undefined: no counter, WAIT holds indefinitely, and the TIMEOUT parameter is unused.

Test Plan:
- Reset asserted mid-WAIT, then div_done pulse after release → state=0, num=den=0, leds=0; the late div_done leaves state at 0.
- From NUM: 3 up presses, ok, 2 up presses, ok, divider model answers div_done with result=1, rest=1 → one div_start pulse, state RES, leds=1; ok → leds=1 (REST); ok → NUM with num=3, den=2.
- Num wrap: down press at num=0 → num=15. up+down on the same edge at num=5 → num stays 5. ok held for 10 cycles → exactly one state advance.
- den=0 then ok → state=6, err=1, leds=15, div_start never asserted; ok → DEN; up, ok → START.
- num=13, den=4, model returns 3 rem 1 after 7 cycles; up presses during WAIT → num/den unchanged, RES leds=3, REST leds=1.
- DIV_TIMEOUT_EN, TIMEOUT=32, no div_done → ERR at the 32nd WAIT cycle, leds=4'b1010; with div_done on that same cycle → RES.

Source files
------------

// File: rtl/div_ui_ctrl.sv
// Button-driven operand entry and start/done sequencing for the 4-bit divider.
// Define DIV_TIMEOUT_EN to abort a hung division into ERR after TIMEOUT cycles.
module div_ui_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             ok,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_result,
  input  logic [WIDTH-1:0] div_rest,
  output logic             div_start,
  output logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] den,
  output logic [2:0]       state,
  output logic             err,
  output logic [WIDTH-1:0] leds
);

  typedef enum logic [2:0] {
    S_NUM   = 3'd0,
    S_DEN   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RES   = 3'd4,
    S_REST  = 3'd5,
    S_ERR   = 3'd6
  } st_t;

  st_t st;
  logic [WIDTH-1:0] res_q, rest_q;
  logic up_q, down_q, ok_q;
  logic up_p, down_p, ok_p;
  logic [WIDTH-1:0] num_nx, den_nx;
  logic to_q;

  assign up_p   = up & ~up_q;
  assign down_p = down & ~down_q;
  assign ok_p   = ok & ~ok_q;

  function automatic logic [WIDTH-1:0] edit(
    input logic [WIDTH-1:0] v,
    input logic             inc,
    input logic             dec
  );
    if (inc && !dec) return v + WIDTH'(1);
    if (dec && !inc) return v - WIDTH'(1);
    return v;
  endfunction

  assign num_nx = edit(num, up_p, down_p);
  assign den_nx = edit(den, up_p, down_p);
  assign state  = st;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_NUM;
      num       <= '0;
      den       <= '0;
      res_q     <= '0;
      rest_q    <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      ok_q      <= 1'b0;
      div_start <= 1'b0;
      err       <= 1'b0;
      to_q      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      up_q      <= up;
      down_q    <= down;
      ok_q      <= ok;
      div_start <= 1'b0;
      case (st)
        S_NUM: begin
          num <= num_nx;
          if (ok_p) st <= S_DEN;
        end
        S_DEN: begin
          // the edit lands first, so the zero check sees the edited value
          den <= den_nx;
          if (ok_p) begin
            if (den_nx == '0) begin
              st  <= S_ERR;
              err <= 1'b1;
            end else begin
              st        <= S_START;
              div_start <= 1'b1;
            end
          end
        end
        S_START: begin
          st <= S_WAIT;
`ifdef DIV_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (div_done) begin
            res_q  <= div_result;
            rest_q <= div_rest;
            st     <= S_RES;
          end
`ifdef DIV_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            st   <= S_ERR;
            err  <= 1'b1;
            to_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_RES:  if (ok_p) st <= S_REST;
        S_REST: if (ok_p) st <= S_NUM;
        S_ERR: begin
          if (ok_p) begin
            st   <= S_DEN;
            err  <= 1'b0;
            to_q <= 1'b0;
          end
        end
        default: begin
          st  <= S_NUM;
          err <= 1'b0;
        end
      endcase
    end
  end

`ifndef DIV_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  localparam logic [2*WIDTH-1:0] ALT2 = {WIDTH{2'b10}};
  localparam logic [WIDTH-1:0]   ALT  = ALT2[WIDTH-1:0];

  always_comb begin
    leds = '0;
    case (st)
      S_NUM:   leds = num;
      S_DEN:   leds = den;
      S_RES:   leds = res_q;
      S_REST:  leds = rest_q;
      S_ERR:   leds = to_q ? ALT : '1;
      default: leds = '0;
    endcase
  end

endmodule
